// File: rtl/dot_product_datapath_if.sv
// Host-side bus of the dot-product datapath: operand/control strobes in, result readback out.
interface dot_product_datapath_if #(
  parameter int unsigned N     = 8,
  parameter int unsigned QA    = 2,
  parameter int unsigned ACC_W = 20
);
  logic signed [N-1:0] x_in;
  logic signed [N-1:0] w_in;
  logic                write_x;
  logic                write_w;
  logic                acc_write;
  logic                clear_acc;
  logic                res_write;
  logic [QA-1:0]       rd_addr;
  logic [ACC_W-1:0]    rd_data;
  logic                y_out;
  logic                res_valid;
  logic [QA:0]         res_count;
  logic                res_full;
  logic                err;

  modport master (
    output x_in, w_in, write_x, write_w, acc_write, clear_acc, res_write, rd_addr,
    input  rd_data, y_out, res_valid, res_count, res_full, err
  );

  modport slave (
    input  x_in, w_in, write_x, write_w, acc_write, clear_acc, res_write, rd_addr,
    output rd_data, y_out, res_valid, res_count, res_full, err
  );
endinterface

// File: rtl/dot_product_datapath.sv
// Signed multiply-accumulate datapath with a Q-entry result buffer and sign activation.
// Optional macro DOT_PRODUCT_SAT_EN: saturating accumulate instead of modulo wrap.
module dot_product_datapath #(
  parameter int unsigned N     = 8,
  parameter int unsigned D     = 4,
  parameter int unsigned Q     = 4,
  parameter int unsigned QA    = 2,
  parameter int unsigned ACC_W = 20
) (
  input logic                    clk,
  input logic                    rst,
  dot_product_datapath_if.slave  bus
);

  localparam int unsigned MSB   = ACC_W - 1;
  localparam logic [QA:0] Q_CNT = (QA + 1)'(Q);

  logic signed [N-1:0]     x_reg;
  logic signed [N-1:0]     w_reg;
  logic signed [2*N-1:0]   prod;
  logic signed [ACC_W-1:0] prod_ext;
  logic signed [ACC_W-1:0] sum;
  logic signed [ACC_W-1:0] acc_sum;
  logic signed [ACC_W-1:0] acc;
  logic [ACC_W-1:0]        mem [Q];
  logic [QA-1:0]           wr_ptr;
  logic [QA:0]             res_count;
  logic                    res_full;
  logic                    res_valid;
  logic                    y_out;
  logic                    err;
  logic [ACC_W-1:0]        rd_data;
  logic                    commit;
  logic                    reject;

  assign prod     = x_reg * w_reg;
  assign prod_ext = ACC_W'(prod);
  assign sum      = acc + prod_ext;

`ifdef DOT_PRODUCT_SAT_EN
  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W - 1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W - 1){1'b0}}};

  // Overflow only when both addends share a sign the result does not.
  always_comb begin
    acc_sum = sum;
    if ((acc[MSB] == prod_ext[MSB]) && (sum[MSB] != acc[MSB])) begin
      acc_sum = acc[MSB] ? ACC_MIN : ACC_MAX;
    end
  end
`else
  always_comb begin
    acc_sum = sum;
  end
`endif

  assign commit = bus.res_write && !res_full;
  assign reject = bus.res_write && res_full;

  always_ff @(posedge clk) begin
    if (rst) begin
      x_reg     <= '0;
      w_reg     <= '0;
      acc       <= '0;
      wr_ptr    <= '0;
      res_count <= '0;
      res_full  <= 1'b0;
      res_valid <= 1'b0;
      y_out     <= 1'b0;
      err       <= 1'b0;
      rd_data   <= '0;
      for (int unsigned i = 0; i < Q; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (bus.write_x) x_reg <= bus.x_in;
      if (bus.write_w) w_reg <= bus.w_in;

      if (bus.clear_acc)      acc <= '0;
      else if (bus.acc_write) acc <= acc_sum;

      // Commit captures the pre-edge accumulator regardless of simultaneous updates.
      res_valid <= commit;
      if (commit) begin
        mem[wr_ptr] <= acc;
        wr_ptr      <= wr_ptr + QA'(1);
        res_count   <= res_count + (QA + 1)'(1);
        res_full    <= ((res_count + (QA + 1)'(1)) == Q_CNT);
        y_out       <= ~acc[MSB];
      end
      if (reject) err <= 1'b1;

      // Readback sees pre-edge memory contents, so a same-edge write shows up next cycle.
      if ({1'b0, bus.rd_addr} >= Q_CNT) rd_data <= '0;
      else                              rd_data <= mem[bus.rd_addr];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) assert (D >= 1 && ACC_W >= 2 * N);
  end

  assign bus.rd_data   = rd_data;
  assign bus.y_out     = y_out;
  assign bus.res_valid = res_valid;
  assign bus.res_count = res_count;
  assign bus.res_full  = res_full;
  assign bus.err       = err;

endmodule

// File: tb/tb_dot_product_datapath.sv
// Directed bench for dot_product_datapath: MAC, commit, priority, full/err, overflow, reset, readback.
module tb_dot_product_datapath;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   passed = 0;
  int   total  = 0;
  logic [31:0] v;

  always #5 clk = ~clk;

  dot_product_datapath_if #(.N(8), .QA(2), .ACC_W(20)) b ();
  dot_product_datapath_if #(.N(8), .QA(2), .ACC_W(20)) b2 ();

  dot_product_datapath #(.N(8), .D(4), .Q(4), .QA(2), .ACC_W(20)) dut (
    .clk (clk),
    .rst (rst),
    .bus (b.slave)
  );

  dot_product_datapath #(.N(8), .D(4), .Q(3), .QA(2), .ACC_W(20)) dut_q3 (
    .clk (clk),
    .rst (rst),
    .bus (b2.slave)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic load(input int x, input int w);
    b.x_in    = 8'(x);
    b.w_in    = 8'(w);
    b.write_x = 1'b1;
    b.write_w = 1'b1;
    step();
    b.write_x = 1'b0;
    b.write_w = 1'b0;
  endtask

  task automatic mac(input int n);
    b.acc_write = 1'b1;
    repeat (n) step();
    b.acc_write = 1'b0;
  endtask

  task automatic commit();
    b.res_write = 1'b1;
    step();
    b.res_write = 1'b0;
  endtask

  task automatic rd(input int a, output logic [31:0] d);
    b.rd_addr = 2'(a);
    step();
    d = 32'(b.rd_data);
  endtask

  initial begin
    b.x_in = '0;  b.w_in = '0;  b.write_x = 0;  b.write_w = 0;
    b.acc_write = 0;  b.clear_acc = 0;  b.res_write = 0;  b.rd_addr = '0;
    b2.x_in = '0; b2.w_in = '0; b2.write_x = 0; b2.write_w = 0;
    b2.acc_write = 0; b2.clear_acc = 0; b2.res_write = 0; b2.rd_addr = '0;

    do_reset();
    check("rst_rd_data",   32'(b.rd_data),   32'h0);
    check("rst_y_out",     32'(b.y_out),     32'h0);
    check("rst_res_valid", 32'(b.res_valid), 32'h0);
    check("rst_res_count", 32'(b.res_count), 32'h0);
    check("rst_res_full",  32'(b.res_full),  32'h0);
    check("rst_err",       32'(b.err),       32'h0);

    // 3*4 - 2*5 + 7*(-1) + 1*1 = -4
    load(3, 4);  mac(1);
    load(-2, 5); mac(1);
    load(7, -1); mac(1);
    load(1, 1);  mac(1);
    commit();
    check("mac_res_valid", 32'(b.res_valid), 32'h1);
    check("mac_y_out",     32'(b.y_out),     32'h0);
    check("mac_res_count", 32'(b.res_count), 32'h1);
    step();
    check("mac_valid_drop", 32'(b.res_valid), 32'h0);
    rd(0, v);
    check("mac_rd0", v, 32'h000FFFFC);

    // clear_acc wins over acc_write; commit takes pre-edge acc
    b.clear_acc = 1'b1; step(); b.clear_acc = 1'b0;
    load(3, 4); mac(1);
    b.clear_acc = 1'b1; b.acc_write = 1'b1; step();
    b.clear_acc = 1'b0; b.acc_write = 1'b0;
    load(2, 3);
    b.res_write = 1'b1; b.acc_write = 1'b1; step();
    b.res_write = 1'b0; b.acc_write = 1'b0;
    check("prio_y_out",     32'(b.y_out),     32'h1);
    check("prio_res_count", 32'(b.res_count), 32'h2);
    rd(1, v);
    check("prio_entry_zero", v, 32'h0);
    commit();
    rd(2, v);
    check("prio_acc_six", v, 32'h6);

    // fill with 1..4, then a rejected commit
    do_reset();
    load(1, 1);
    for (int i = 0; i < 4; i++) begin
      mac(1);
      commit();
    end
    check("full_res_full",  32'(b.res_full),  32'h1);
    check("full_res_count", 32'(b.res_count), 32'h4);
    check("full_err_low",   32'(b.err),       32'h0);
    mac(1);
    commit();
    check("over_err",       32'(b.err),       32'h1);
    check("over_res_valid", 32'(b.res_valid), 32'h0);
    check("over_res_count", 32'(b.res_count), 32'h4);
    check("over_y_out",     32'(b.y_out),     32'h1);
    for (int i = 0; i < 4; i++) begin
      rd(i, v);
      check($sformatf("over_mem%0d", i), v, 32'(i + 1));
    end

    // reset in the middle of accumulation
    mac(2);
    commit();
    do_reset();
    check("mid_res_count", 32'(b.res_count), 32'h0);
    check("mid_res_full",  32'(b.res_full),  32'h0);
    check("mid_err",       32'(b.err),       32'h0);
    for (int i = 0; i < 4; i++) begin
      rd(i, v);
      check($sformatf("mid_mem%0d", i), v, 32'h0);
    end
    load(5, 1); mac(1); commit();
    check("mid_res_count1", 32'(b.res_count), 32'h1);
    rd(0, v);
    check("mid_first_slot", v, 32'h5);
    rd(1, v);
    check("mid_second_slot", v, 32'h0);

    // 32 * 16384 = 2^19 exceeds the signed 20-bit range
    do_reset();
    load(-128, -128);
    mac(32);
    commit();
    rd(0, v);
`ifdef DOT_PRODUCT_SAT_EN
    check("ovf_value", v, 32'h0007FFFF);
    check("ovf_y_out", 32'(b.y_out), 32'h1);
`else
    check("ovf_value", v, 32'h00080000);
    check("ovf_y_out", 32'(b.y_out), 32'h0);
`endif

    // Q=3 instance: collision on first commit, then out-of-range read
    b2.x_in = 8'(9); b2.w_in = 8'(1); b2.write_x = 1'b1; b2.write_w = 1'b1; step();
    b2.write_x = 1'b0; b2.write_w = 1'b0;
    b2.acc_write = 1'b1; step(); b2.acc_write = 1'b0;
    b2.rd_addr = 2'd0; b2.res_write = 1'b1; step(); b2.res_write = 1'b0;
    check("col_old", 32'(b2.rd_data), 32'h0);
    step();
    check("col_new", 32'(b2.rd_data), 32'h9);
    b2.rd_addr = 2'd3; step();
    check("oor_rd3", 32'(b2.rd_data), 32'h0);
    b2.res_write = 1'b1; step(); step(); b2.res_write = 1'b0;
    check("q3_res_count", 32'(b2.res_count), 32'h3);
    check("q3_res_full",  32'(b2.res_full),  32'h1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
